uc_sequencer: RTL and testbench

Control unit for the 8-bit accumulator datapath. It fetches instructions from a 64-word synchronous memory, decodes them, and drives the processing unit's control strobes (`sel_UAL`, `load_R1`, `load_accu`, `load_carry`, `init_carry`). It sits directly upstream of the processing unit, which consumes those strobes and returns its registered carry flag. The instruction set has four opcodes: NOR, ADD, STA and JCC.

---
 rtl/uc_sequencer.sv | 133 +++++++++++++
 tb/tb_uc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uc_sequencer.sv
// Control unit for the 8-bit accumulator datapath: fetches, decodes and
// sequences NOR/ADD/STA/JCC instructions from a 64-word synchronous memory.
module uc_sequencer #(
  parameter int          ADDR_W  = 6,
  parameter logic [2:0]  SEL_ADD = 3'b000,
  parameter logic [2:0]  SEL_NOR = 3'b001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [7:0]        mem_rdata,
  input  logic              carry,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              ins_done
);

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_ADD = 2'b01,
    OP_STA = 2'b10,
    OP_JCC = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPFETCH,
    S_LOADR1,
    S_EXEC,
    S_STORE,
    S_JUMP
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  opcode_t           w_ir_op;
  opcode_t           w_rd_op;
  logic              w_run;

  assign w_ir_op = opcode_t'(r_ir[7:6]);
  assign w_rd_op = opcode_t'(mem_rdata[7:6]);
  // Strobes are gated by reset as well as ce so FETCH's mem_en stays low in reset.
  assign w_run   = ce & rst_n;
  assign pc      = r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else if (ce) begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_ir <= mem_rdata;
        r_pc <= r_pc + ADDR_W'(1);
      end else if (r_state == S_JUMP && !carry) begin
        r_pc <= r_ir[ADDR_W-1:0];
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:   w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_rd_op)
          OP_NOR, OP_ADD: w_next_state = S_OPFETCH;
          OP_STA:         w_next_state = S_STORE;
          default:        w_next_state = S_JUMP;
        endcase
      end
      S_OPFETCH: w_next_state = S_LOADR1;
      S_LOADR1:  w_next_state = S_EXEC;
      default:   w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_addr   = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    sel_UAL    = SEL_ADD;
    load_R1    = 1'b0;
    load_accu  = 1'b0;
    load_carry = 1'b0;
    init_carry = 1'b0;
    ins_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_addr = r_pc;
        mem_en   = w_run;
      end
      S_OPFETCH: begin
        mem_addr = r_ir[ADDR_W-1:0];
        mem_en   = w_run;
      end
      S_LOADR1: load_R1 = w_run;
      S_EXEC: begin
        sel_UAL    = (w_ir_op == OP_NOR) ? SEL_NOR : SEL_ADD;
        load_accu  = w_run;
        load_carry = w_run & (w_ir_op == OP_ADD);
        ins_done   = w_run;
      end
      S_STORE: begin
        mem_addr = r_ir[ADDR_W-1:0];
        mem_en   = w_run;
        mem_we   = w_run;
        ins_done = w_run;
      end
      S_JUMP: begin
        init_carry = w_run;
        ins_done   = w_run;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer with a behavioural memory and processing
// unit; expected values are hand-computed from the programs loaded below.
module tb_uc_sequencer;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_NOR = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] mem_rdata;
  logic       carry;
  logic [5:0] mem_addr;
  logic       mem_en, mem_we;
  logic [2:0] sel_UAL;
  logic       load_R1, load_accu, load_carry, init_carry;
  logic [5:0] pc;
  logic       ins_done;

  int checks = 0;
  int errors = 0;

  uc_sequencer #(.ADDR_W(6), .SEL_ADD(SEL_ADD), .SEL_NOR(SEL_NOR)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mem_rdata(mem_rdata), .carry(carry),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .sel_UAL(sel_UAL),
    .load_R1(load_R1), .load_accu(load_accu), .load_carry(load_carry),
    .init_carry(init_carry), .pc(pc), .ins_done(ins_done)
  );

  always #5 clk = ~clk;

  // Synchronous memory with a bench-side load port
  logic [7:0] mem [64];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] acc, r1;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= acc;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Processing unit model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; r1 <= '0; carry <= 1'b0;
    end else begin
      if (load_R1) r1 <= mem_rdata;
      if (load_accu) acc <= (sel_UAL == SEL_NOR) ? ~(acc | r1) : acc + r1;
      if (load_carry) carry <= ({1'b0, acc} + {1'b0, r1}) > 9'd255;
      if (init_carry) carry <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Program A: NOR 62, ADD 63, STA 61, JCC 5 (carry=1), JCC 5 (carry=0), JCC 5 loop
    load(6'd0, 8'h3E); load(6'd62, 8'h00);
    load(6'd1, 8'h7F); load(6'd63, 8'h01);
    load(6'd2, 8'hBD); load(6'd61, 8'hAA);
    load(6'd3, 8'hC5); load(6'd4, 8'hC5); load(6'd5, 8'hC5);
    check("rst_mem_en", mem_en, 0);
    check("rst_strobes", {mem_we, load_R1, load_accu, load_carry, init_carry, ins_done}, 0);
    check("rst_pc", pc, 0);
    rst_n = 1'b1; #1;
    check("fetch0_en", mem_en, 1);
    check("fetch0_addr", mem_addr, 0);
    check("fetch0_pc", pc, 0);

    tick(); check("decode0_en", mem_en, 0);
    tick(); check("opf0", {mem_en, mem_addr}, {1'b1, 6'd62}); check("opf0_pc", pc, 1);
    tick(); check("ldr1_0", {load_R1, mem_en}, 2'b10);
    tick(); check("exec_nor_sel", sel_UAL, SEL_NOR);
    check("exec_nor_strb", {load_accu, load_carry, ins_done}, 3'b101);
    check("exec_nor_pc", pc, 1);
    tick(); check("fetch1", {mem_en, mem_addr, ins_done}, {1'b1, 6'd1, 1'b0});
    check("nor_acc", acc, 8'hFF);

    tick(); tick(); check("opf1_addr", mem_addr, 63);
    tick(); tick(); check("exec_add_sel", sel_UAL, SEL_ADD);
    check("exec_add_strb", {load_accu, load_carry, ins_done}, 3'b111);
    tick(); check("fetch2_addr", mem_addr, 2);
    check("add_acc_carry", {carry, acc}, 9'h100);

    tick(); check("decode2_we", mem_we, 0);
    tick(); check("store", {mem_en, mem_we, mem_addr, ins_done}, {2'b11, 6'd61, 1'b1});
    tick(); check("fetch3", {mem_we, mem_addr, pc}, {1'b0, 6'd3, 6'd3});
    check("sta_mem61", mem[61], 8'h00);

    tick(); tick(); check("jcc_c1_strb", {init_carry, ins_done}, 2'b11);
    check("jcc_c1_pc", pc, 4);
    tick(); check("fetch4", {pc, mem_addr}, {6'd4, 6'd4});
    check("carry_cleared", carry, 0);
    tick(); tick(); tick(); check("jcc_taken_fetch", {pc, mem_addr}, {6'd5, 6'd5});
    for (int k = 0; k < 3; k++) begin
      tick(); tick(); check($sformatf("loop%0d_jump", k), {ins_done, pc}, {1'b1, 6'd6});
      tick(); check($sformatf("loop%0d_fetch", k), {ins_done, mem_en, pc}, {2'b01, 6'd5});
    end

    // Program B: JCC 63 then STA 62 at address 63; pc wraps to 0
    rst_n = 1'b0;
    load(6'd0, 8'hFF); load(6'd63, 8'hBE);
    rst_n = 1'b1; #1;
    tick(); tick(); tick(); check("fetch63", {pc, mem_addr}, {6'd63, 6'd63});
    tick(); tick(); check("store62", {mem_we, mem_addr}, {1'b1, 6'd62});
    tick(); check("wrap_fetch", {mem_en, mem_addr, pc}, {1'b1, 6'd0, 6'd0});

    // Program C: ADD 4 with ce dropped in OPFETCH, then STA 5 aborted by reset
    rst_n = 1'b0;
    load(6'd0, 8'h44); load(6'd4, 8'h03); load(6'd1, 8'h85); load(6'd5, 8'h55);
    rst_n = 1'b1; #1;
    tick(); tick(); check("opfc", {mem_en, mem_addr, pc}, {1'b1, 6'd4, 6'd1});
    ce = 1'b0; #1;
    check("ce0_en", {mem_en, mem_addr}, {1'b0, 6'd4});
    for (int k = 0; k < 4; k++) begin
      tick(); check($sformatf("ce0_hold%0d", k), {mem_en, load_R1, mem_addr, pc}, {2'b00, 6'd4, 6'd1});
    end
    ce = 1'b1; #1;
    check("ce1_reissue", {mem_en, mem_addr}, {1'b1, 6'd4});
    tick(); check("ce1_ldr1", load_R1, 1);
    tick(); check("ce1_exec", {load_accu, load_carry, ins_done}, 3'b111);
    tick(); check("add_acc", acc, 8'h03);
    tick(); tick(); check("storec", {mem_we, mem_addr}, {1'b1, 6'd5});
    rst_n = 1'b0; #1;
    check("rst_we_fall", {mem_we, mem_en, ins_done}, 0);
    check("rst_pc0", pc, 0);
    tick(); check("no_partial_write", mem[5], 8'h55);
    rst_n = 1'b1; #1;
    check("post_rst_fetch", {mem_en, mem_addr}, {1'b1, 6'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
